// File: rtl/sys_bridge_pkg.sv
// +----------------------------------------------------------------------+
// | sys_bridge_pkg : shared constants and types for the CPU/IO bridge    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package sys_bridge_pkg;

   localparam logic [31:0] C_DEV_BASE  = 32'h0000_7F00;
   localparam int unsigned C_DEV_SPAN  = 16;
   localparam logic [31:0] C_CTRL_BASE = 32'h0000_7F80;

   // Control window register index, taken from PrAddr[3:2]
   typedef enum logic [1:0] {
      REG_PEND    = 2'd0,
      REG_MASK    = 2'd1,
      REG_ERRADDR = 2'd2,
      REG_STATUS  = 2'd3
   } ctrl_reg_e;

endpackage

`default_nettype wire

// File: rtl/bridge_irq_cell.sv
// +----------------------------------------------------------------------+
// | bridge_irq_cell : one interrupt line, edge or level, with W1C pend   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bridge_irq_cell #(
   parameter bit EDGE = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_irq,
   input  logic i_clr,
   output logic o_pend
);

   logic irq_d, irq_q;
   logic pend_d, pend_q;

   always_comb begin
      irq_d = i_irq;
      if (EDGE) begin
         // A new rising edge beats a simultaneous clear
         pend_d = (i_irq & ~irq_q) | (pend_q & ~i_clr);
      end else begin
         pend_d = i_irq;
      end
   end

   // Edge history keeps tracking through reset so a line already high at release is not an edge
   always_ff @(posedge clk) begin
      irq_q <= irq_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign o_pend = pend_q;

endmodule

`default_nettype wire

// File: rtl/sys_bridge.sv
// +----------------------------------------------------------------------+
// | sys_bridge : CPU-to-peripheral bridge, window decode, IRQ and errors |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module sys_bridge
   import sys_bridge_pkg::*;
#(
   parameter int unsigned NUM_DEV   = 6,
   parameter logic [31:0] DEV_BASE  = C_DEV_BASE,
   parameter int unsigned DEV_SPAN  = C_DEV_SPAN,
   parameter logic [31:0] CTRL_BASE = C_CTRL_BASE,
   parameter logic [5:0]  IRQ_EDGE  = 6'b000000,
   parameter logic [5:0]  MASK_RST  = 6'b111111
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            PrAddr,
   input  logic                   PrWE,
   input  logic                   PrRE,
   input  logic [31:0]            PrWD,
   output logic [31:0]            PrRD,
   output logic [31:0]            DevAddr,
   output logic [31:0]            DevWD,
   output logic [NUM_DEV-1:0]     DevWE,
   input  logic [32*NUM_DEV-1:0]  DevRD,
   input  logic [NUM_DEV-1:0]     DevIrq,
   output logic [5:0]             HWInt,
   output logic                   BusErr
);

   logic [NUM_DEV-1:0] dev_hit;
   logic [NUM_DEV-1:0] pend;
   logic [NUM_DEV-1:0] pend_clr;
   logic               ctrl_hit;
   logic               ctrl_wr;
   logic               unmapped;
   logic               err_clr;
   ctrl_reg_e          reg_sel;
   logic [5:0]         pend_ext;
   logic [31:0]        dev_rd;
   logic [31:0]        ctrl_rd;

   logic [5:0]  mask_d, mask_q;
   logic [5:0]  hwint_d, hwint_q;
   logic        err_d, err_q;
   logic        buserr_d, buserr_q;
   logic [31:0] erraddr_d, erraddr_q;

   generate
      for (genvar i = 0; i < NUM_DEV; i++) begin : g_dev
         localparam logic [31:0] LO = DEV_BASE + 32'(i * DEV_SPAN);
         localparam logic [31:0] HI = LO + 32'(DEV_SPAN);

         assign dev_hit[i] = (PrAddr >= LO) && (PrAddr < HI);

         bridge_irq_cell #(
            .EDGE (IRQ_EDGE[i])
         ) u_irq_cell (
            .clk    (clk),
            .reset  (reset),
            .i_irq  (DevIrq[i]),
            .i_clr  (pend_clr[i]),
            .o_pend (pend[i])
         );
      end
   endgenerate

   assign ctrl_hit = (PrAddr[31:4] == CTRL_BASE[31:4]);
   assign reg_sel  = ctrl_reg_e'(PrAddr[3:2]);
   assign ctrl_wr  = PrWE & ctrl_hit;
   assign unmapped = (PrWE | PrRE) & ~(|dev_hit) & ~ctrl_hit;
   assign DevWD    = PrWD;
   assign DevWE    = {NUM_DEV{PrWE}} & dev_hit;

   always_comb begin
      DevAddr = '0;
      dev_rd  = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (dev_hit[i]) begin
            DevAddr = PrAddr - (DEV_BASE + 32'(i) * 32'(DEV_SPAN));
            dev_rd  = DevRD[32*i +: 32];
         end
      end
   end

   always_comb begin
      pend_ext              = '0;
      pend_ext[NUM_DEV-1:0] = pend;
   end

   always_comb begin
      ctrl_rd = '0;
      case (reg_sel)
         REG_PEND:    ctrl_rd = {26'd0, pend_ext};
         REG_MASK:    ctrl_rd = {26'd0, mask_q};
         REG_ERRADDR: ctrl_rd = erraddr_q;
         REG_STATUS:  ctrl_rd = {31'd0, err_q};
         default:     ctrl_rd = '0;
      endcase
   end

   always_comb begin
      PrRD = '0;
      if (|dev_hit) begin
         PrRD = dev_rd;
      end else if (ctrl_hit) begin
         PrRD = ctrl_rd;
      end
   end

   always_comb begin
      pend_clr  = '0;
      mask_d    = mask_q;
      err_d     = err_q;
      erraddr_d = erraddr_q;
      err_clr   = ctrl_wr && (reg_sel == REG_STATUS) && PrWD[0];
      if (ctrl_wr && (reg_sel == REG_PEND)) begin
         pend_clr = PrWD[NUM_DEV-1:0];
      end
      if (ctrl_wr && (reg_sel == REG_MASK)) begin
         mask_d = PrWD[5:0];
      end
      if (err_clr) begin
         err_d = 1'b0;
      end
      // First error address is sticky until ERR is cleared
      if (unmapped) begin
         err_d = 1'b1;
         if (!err_q || err_clr) begin
            erraddr_d = PrAddr;
         end
      end
      hwint_d  = pend_ext & mask_q;
      buserr_d = unmapped;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q    <= MASK_RST;
         hwint_q   <= '0;
         err_q     <= 1'b0;
         erraddr_q <= '0;
         buserr_q  <= 1'b0;
      end else begin
         mask_q    <= mask_d;
         hwint_q   <= hwint_d;
         err_q     <= err_d;
         erraddr_q <= erraddr_d;
         buserr_q  <= buserr_d;
      end
   end

   assign HWInt  = hwint_q;
   assign BusErr = buserr_q;

endmodule

`default_nettype wire

// File: tb/tb_sys_bridge.sv
// +----------------------------------------------------------------------+
// | tb_sys_bridge : directed self-checking bench for sys_bridge          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sys_bridge;

   localparam int NUM_DEV = 6;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [31:0]           PrAddr;
   logic                  PrWE;
   logic                  PrRE;
   logic [31:0]           PrWD;
   logic [31:0]           PrRD;
   logic [31:0]           DevAddr;
   logic [31:0]           DevWD;
   logic [NUM_DEV-1:0]    DevWE;
   logic [32*NUM_DEV-1:0] DevRD;
   logic [NUM_DEV-1:0]    DevIrq;
   logic [5:0]            HWInt;
   logic                  BusErr;

   int checks   = 0;
   int failures = 0;

   sys_bridge #(
      .NUM_DEV  (NUM_DEV),
      .IRQ_EDGE (6'b000011)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .PrAddr  (PrAddr),
      .PrWE    (PrWE),
      .PrRE    (PrRE),
      .PrWD    (PrWD),
      .PrRD    (PrRD),
      .DevAddr (DevAddr),
      .DevWD   (DevWD),
      .DevWE   (DevWE),
      .DevRD   (DevRD),
      .DevIrq  (DevIrq),
      .HWInt   (HWInt),
      .BusErr  (BusErr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic        re;
      logic [31:0] wd;
      logic [31:0] rd;
      logic [5:0]  dwe;
      logic [31:0] daddr;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
      PrAddr = addr;
      PrWD   = data;
      PrWE   = 1'b1;
      tick();
      PrWE   = 1'b0;
      PrAddr = 32'h0;
   endtask

   task automatic rd_reg(input logic [31:0] addr, output logic [31:0] data);
      PrAddr = addr;
      #1;
      data   = PrRD;
      PrAddr = 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;

      reset  = 1'b1;
      PrAddr = 32'h0;
      PrWE   = 1'b0;
      PrRE   = 1'b0;
      PrWD   = 32'h0;
      DevIrq = '0;
      DevRD  = {32'h0000_1555, 32'h0000_1444, 32'h0000_1333,
                32'h0000_CAFE, 32'h0000_1111, 32'h0000_1000};

      vecs[0] = '{32'h7F14, 1'b1, 1'b0, 32'h1234, 32'h1111, 6'b000010, 32'h4};
      vecs[1] = '{32'h7F24, 1'b0, 1'b1, 32'h0000, 32'hCAFE, 6'b000000, 32'h4};
      vecs[2] = '{32'h7F00, 1'b1, 1'b0, 32'h0005, 32'h1000, 6'b000001, 32'h0};
      vecs[3] = '{32'h7F0F, 1'b1, 1'b0, 32'h0006, 32'h1000, 6'b000001, 32'hF};
      vecs[4] = '{32'h7F10, 1'b0, 1'b1, 32'h0007, 32'h1111, 6'b000000, 32'h0};
      vecs[5] = '{32'h7F5F, 1'b1, 1'b0, 32'h0008, 32'h1555, 6'b100000, 32'hF};
      vecs[6] = '{32'h7F60, 1'b0, 1'b0, 32'h0009, 32'h0000, 6'b000000, 32'h0};
      vecs[7] = '{32'h7F84, 1'b0, 1'b1, 32'h000A, 32'h003F, 6'b000000, 32'h0};
      vecs[8] = '{32'h7F8C, 1'b0, 1'b1, 32'h000B, 32'h0000, 6'b000000, 32'h0};
      vecs[9] = '{32'h7F3A, 1'b1, 1'b0, 32'h000C, 32'h1333, 6'b001000, 32'hA};

      repeat (3) tick();
      check("rst_hwint",   HWInt,  6'h00);
      check("rst_buserr",  BusErr, 1'b0);
      rd_reg(32'h7F80, r); check("rst_pend",    r, 32'h0);
      rd_reg(32'h7F84, r); check("rst_mask",    r, 32'h3F);
      rd_reg(32'h7F88, r); check("rst_erraddr", r, 32'h0);
      rd_reg(32'h7F8C, r); check("rst_status",  r, 32'h0);
      reset = 1'b0;
      tick();

      // Combinational decode table
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         PrAddr = vecs[i].addr;
         PrWE   = vecs[i].we;
         PrRE   = vecs[i].re;
         PrWD   = vecs[i].wd;
         #1;
         check($sformatf("vec%0d_prrd", i),    PrRD,    vecs[i].rd);
         check($sformatf("vec%0d_devwe", i),   DevWE,   vecs[i].dwe);
         check($sformatf("vec%0d_devaddr", i), DevAddr, vecs[i].daddr);
         check($sformatf("vec%0d_devwd", i),   DevWD,   vecs[i].wd);
      end
      PrWE = 1'b0; PrRE = 1'b0; PrAddr = 32'h0;
      tick();
      check("decode_no_buserr", BusErr, 1'b0);

      // Edge interrupt on line 0, then W1C while line stays high
      DevIrq[0] = 1'b1;
      tick();
      rd_reg(32'h7F80, r); check("edge_pend_set", r, 32'h1);
      check("edge_hwint_lag", HWInt, 6'h00);
      tick();
      check("edge_hwint", HWInt, 6'h01);
      bus_wr(32'h7F80, 32'h1);
      rd_reg(32'h7F80, r); check("edge_pend_clr", r, 32'h0);
      repeat (2) tick();
      rd_reg(32'h7F80, r); check("edge_no_reset", r, 32'h0);
      check("edge_hwint_clr", HWInt, 6'h00);

      // Rising edge and W1C in the same cycle on line 1
      DevIrq[1] = 1'b1;
      bus_wr(32'h7F80, 32'h2);
      rd_reg(32'h7F80, r); check("collide_set_wins", r, 32'h2);
      bus_wr(32'h7F80, 32'h2);
      rd_reg(32'h7F80, r); check("collide_clear", r, 32'h0);

      // Level line 2 ignores W1C and follows the input
      DevIrq[2] = 1'b1;
      tick();
      rd_reg(32'h7F80, r); check("level_pend", r, 32'h4);
      bus_wr(32'h7F80, 32'h4);
      rd_reg(32'h7F80, r); check("level_w1c_ignored", r, 32'h4);
      DevIrq[2] = 1'b0;
      tick();
      rd_reg(32'h7F80, r); check("level_drop", r, 32'h0);

      // Mask gating
      bus_wr(32'h7F84, 32'h3E);
      DevIrq[0] = 1'b0;
      tick();
      DevIrq[0] = 1'b1;
      tick();
      rd_reg(32'h7F80, r); check("mask_pend", r, 32'h1);
      tick();
      check("mask_hwint_off", HWInt, 6'h00);
      bus_wr(32'h7F84, 32'h1);
      tick();
      check("mask_hwint_on", HWInt, 6'h01);

      // Unmapped accesses
      PrAddr = 32'h9000;
      PrRE   = 1'b1;
      #1;
      check("err_prrd", PrRD, 32'h0);
      check("err_pre_pulse", BusErr, 1'b0);
      tick();
      check("err_pulse", BusErr, 1'b1);
      PrRE = 1'b0; PrAddr = 32'h0;
      tick();
      check("err_pulse_end", BusErr, 1'b0);
      rd_reg(32'h7F88, r); check("err_addr", r, 32'h9000);
      rd_reg(32'h7F8C, r); check("err_status", r, 32'h1);
      PrAddr = 32'hA000;
      PrWE   = 1'b1;
      tick();
      PrWE = 1'b0; PrAddr = 32'h0;
      check("err2_pulse", BusErr, 1'b1);
      rd_reg(32'h7F88, r); check("err2_addr_kept", r, 32'h9000);
      bus_wr(32'h7F8C, 32'h1);
      rd_reg(32'h7F8C, r); check("err_w1c", r, 32'h0);
      rd_reg(32'h7F88, r); check("err_addr_after_w1c", r, 32'h9000);
      PrAddr = 32'hB000;
      PrWE   = 1'b1;
      tick();
      PrWE = 1'b0; PrAddr = 32'h0;
      rd_reg(32'h7F88, r); check("err3_addr", r, 32'hB000);
      rd_reg(32'h7F8C, r); check("err3_status", r, 32'h1);

      // Reset mid-run with all lines high
      DevIrq = '0;
      tick();
      DevIrq = 6'h3F;
      tick();
      rd_reg(32'h7F80, r); check("pre_rst_pend", r, 32'h3F);
      bus_wr(32'h7F84, 32'h0);
      rd_reg(32'h7F84, r); check("pre_rst_mask", r, 32'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rd_reg(32'h7F80, r); check("mid_rst_pend", r, 32'h0);
      rd_reg(32'h7F84, r); check("mid_rst_mask", r, 32'h3F);
      rd_reg(32'h7F8C, r); check("mid_rst_status", r, 32'h0);
      rd_reg(32'h7F88, r); check("mid_rst_erraddr", r, 32'h0);
      check("mid_rst_hwint", HWInt, 6'h00);
      check("mid_rst_buserr", BusErr, 1'b0);
      tick();
      rd_reg(32'h7F80, r); check("post_rst_no_edge", r, 32'h3C);
      tick();
      check("post_rst_hwint", HWInt, 6'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
